pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined N-bit adder/subtractor with valid/ready handshakes on both sides. The carry chain is split into STAGES equal chunks, one register boundary per chunk, so wide adds close timing at one result per clock. It is the sequential successor to the combinational ripple_carry_adder and serves as the add/sub datapath element for the ALU and accumulator blocks.

## Interface
- N, default 8: operand and result width; must be a multiple of STAGES.
- STAGES, default 2: pipeline depth and chunk count; CHUNK = N/STAGES bits per stage; STAGES ≥ 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  N  operand A, unsigned or two's complement.
- B  input  N  operand B.
- Cin  input  1  carry-in, used only when Sub=0.
- Sub  input  1  0: A+B+Cin; 1: A−B, computed as A+~B+1, with Cin ignored.
- in_valid  input  1  operands valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- Sum  output  N  result.
- Cout  output  1  carry out of bit N−1; for Sub it is 1 when no borrow occurs (A ≥ B unsigned).
- Ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- out_valid  output  1  Sum, Cout and Ovf are valid.
- out_ready  input  1  downstream consumes the result this cycle.

## Operation
- Global advance enable: en = !out_valid || out_ready. in_ready = en, combinational.
- Accept: a transaction enters stage 0 on an edge where in_valid && in_ready. If in_valid=0 while en=1, a bubble (valid=0) enters.
- Stage k (0..STAGES−1):
  - Adds chunk k of A and of the effective B (B, or ~B when Sub=1).
  - Its carry-in is the registered carry from stage k−1. Stage 0 uses Cin when Sub=0 and 1 when Sub=1.
  - Unprocessed upper chunks of A and effective B are carried forward in skew registers.
  - Completed lower sum chunks are carried forward alongside them.
- Final stage:
  - Registers the full Sum and Cout.
  - Registers Ovf, computed from the MSB carry-in and carry-out of the last chunk.
- Every stage register, including its valid bit, loads only when en=1. When en=0, all stages hold, so bubbles are not compressed.
- Results leave in acceptance order. There is no reordering or dropping.
- Arithmetic is modulo 2^N. Cout and Ovf are the only indication of wrap-around.
- STAGES=1 gives a single registered N-bit adder.

## Timing
- Latency: a transaction accepted at edge t appears with out_valid=1 after edge t+STAGES−1, i.e. it is visible during the cycle following the STAGES-th edge counting acceptance. This holds when no stall occurs.
- Throughput: one result per cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0 forces in_ready=0. Sum, Cout, Ovf and out_valid then hold stable until the transfer completes.
- Simultaneous output transfer and input accept in the same cycle is allowed and required for full throughput.
- Reset values (after any edge with rst=1): all valid bits 0, out_valid=0, Sum=0, Cout=0, Ovf=0, all internal data registers 0.
- Reset is synchronous and overrides en.
- Reset mid-operation discards all in-flight transactions. No stale result appears after rst falls.
- in_ready is 1 in the first cycle after reset, because out_valid=0.
- Sub and Cin are sampled with A and B at acceptance and travel with the transaction. Mixed add/sub streams are therefore legal back-to-back.

## Test plan
All scenarios use N=8, STAGES=2 unless noted.
- Basic add: A=0x00, B=0x00, Cin=0 → Sum=0x00, Cout=0, Ovf=0, out_valid=1 exactly 2 edges after accept. Then A=0x03, B=0x05, Cin=1 → Sum=0x09.
- Chunk carry and wrap:
  - A=0xFF, B=0x01, Cin=0 → Sum=0x00, Cout=1, Ovf=0 (carry crosses the stage-0/stage-1 boundary).
  - A=0x0F, B=0x01 → Sum=0x10, Cout=0.
- Signed overflow:
  - A=0x7F, B=0x01 add → Sum=0x80, Cout=0, Ovf=1.
  - A=0x80, B=0x80 add → Sum=0x00, Cout=1, Ovf=1.
- Subtract:
  - A=0x05, B=0x07, Sub=1, Cin=1 → Sum=0xFE, Cout=0, Ovf=0. Cin must be ignored.
  - A=0x80, B=0x01, Sub=1 → Sum=0x7F, Cout=1, Ovf=1.
- Streaming and backpressure:
  - Four consecutive accepts (0x10+0x01, 0x20+0x02, 0x30+0x03, 0x40+0x04) with out_ready=1 → 0x11, 0x22, 0x33, 0x44 on four consecutive cycles.
  - Repeat with out_ready=0 for 3 cycles after the first result → in_ready=0 and outputs frozen during the stall. All four results are delivered in order with none lost or duplicated.
  - Repeat the streaming case with STAGES=1 and STAGES=4 (N=8) → latency 1 and 4 respectively.
- Reset mid-flight: accept two transactions, then assert rst for 1 cycle before either emerges → out_valid=0 and Sum=0 the cycle after reset. No result appears for the discarded operations. in_ready=1 after rst falls.

Source files
------------

// File: rtl/pipelined_adder.sv
// pipelined_adder: N-bit adder/subtractor with the carry chain split into
// STAGES equal chunks, one register boundary per chunk. Valid/ready on both
// sides; a single global enable advances or holds every stage together.
module pipelined_adder #(
  parameter int unsigned N      = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         Sub,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Ovf,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int unsigned CHUNK = N / STAGES;
  localparam int unsigned LAST  = STAGES - 1;

  // Per-stage registers: skewed operands, partial sum, chunk carry-out, valid.
  // Operand registers keep the full width; each stage only consumes its own chunk.
  logic [N-1:0] a_q [STAGES];
  logic [N-1:0] a_d [STAGES];
  logic [N-1:0] b_q [STAGES];
  logic [N-1:0] b_d [STAGES];
  logic [N-1:0] s_q [STAGES];
  logic [N-1:0] s_d [STAGES];
  logic         c_q [STAGES];
  logic         c_d [STAGES];
  logic         v_q [STAGES];
  logic         v_d [STAGES];
  logic         ovf_q;
  logic         ovf_d;

  // Values presented to each stage's adder (inputs for stage 0, previous register otherwise).
  logic [N-1:0] in_a [STAGES];
  logic [N-1:0] in_b [STAGES];
  logic [N-1:0] in_s [STAGES];
  logic         in_c [STAGES];
  logic [CHUNK:0] csum;

  logic en;

  assign en        = !v_q[LAST] || out_ready;
  assign in_ready  = en;
  assign Sum       = s_q[LAST];
  assign Cout      = c_q[LAST];
  assign Ovf       = ovf_q;
  assign out_valid = v_q[LAST];

  // Stage input selection: stage 0 takes the port operands (B inverted for subtract,
  // carry-in forced to 1), later stages take the previous stage's registers.
  always_comb begin
    in_a[0] = A;
    in_b[0] = B ^ {N{Sub}};
    in_s[0] = '0;
    in_c[0] = Sub ? 1'b1 : Cin;
    v_d[0]  = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      in_a[k] = a_q[k-1];
      in_b[k] = b_q[k-1];
      in_s[k] = s_q[k-1];
      in_c[k] = c_q[k-1];
      v_d[k]  = v_q[k-1];
    end
  end

  // Chunk adders: stage k fills in sum chunk k and passes everything else forward.
  // Overflow = carry into MSB ^ carry out; carry into MSB recovered as a^b^sum at the MSB.
  always_comb begin
    csum = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      csum = {1'b0, in_a[k][k*CHUNK +: CHUNK]}
           + {1'b0, in_b[k][k*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, in_c[k]};
      a_d[k] = in_a[k];
      b_d[k] = in_b[k];
      s_d[k] = in_s[k];
      s_d[k][k*CHUNK +: CHUNK] = csum[CHUNK-1:0];
      c_d[k] = csum[CHUNK];
    end
    ovf_d = in_a[LAST][N-1] ^ in_b[LAST][N-1] ^ s_d[LAST][N-1] ^ c_d[LAST];
  end

  // Pipeline registers: synchronous reset clears everything; otherwise all stages
  // advance together on en, so bubbles are never compressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (en) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vectors, latency for
// STAGES=1/2/4, backpressure, randomized mixed add/sub with a queue model,
// and reset during flight.
module tb_pipelined_adder;

  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, Cin, Sub, in_valid, out_ready;
  logic [N-1:0] A, B;
  logic         rdy1, rdy2, rdy4, ov1, ov2, ov4, co1, co2, co4, of1, of2, of4;
  logic [N-1:0] s1, s2, s4;

  int n_cmp = 0;
  int n_err = 0;

  pipelined_adder #(.N(N), .STAGES(1)) u1 (
    .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .Sub(Sub), .in_valid(in_valid),
    .in_ready(rdy1), .Sum(s1), .Cout(co1), .Ovf(of1), .out_valid(ov1), .out_ready(out_ready));
  pipelined_adder #(.N(N), .STAGES(2)) u2 (
    .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .Sub(Sub), .in_valid(in_valid),
    .in_ready(rdy2), .Sum(s2), .Cout(co2), .Ovf(of2), .out_valid(ov2), .out_ready(out_ready));
  pipelined_adder #(.N(N), .STAGES(4)) u4 (
    .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .Sub(Sub), .in_valid(in_valid),
    .in_ready(rdy4), .Sum(s4), .Cout(co4), .Ovf(of4), .out_valid(ov4), .out_ready(out_ready));

  // Reference: integer arithmetic, result packed as {Ovf, Cout, Sum}.
  function automatic logic [N+1:0] model(input logic [N-1:0] a, b, input logic cin, sub);
    int ua, ub, sa, sb, u, s;
    logic [31:0] uu;
    logic co, of;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      u  = ua - ub;
      s  = sa - sb;
      co = (ua >= ub);
    end else begin
      u  = ua + ub + int'(cin);
      s  = sa + sb + int'(cin);
      co = (u >= (1 << N));
    end
    of = (s > (1 << (N-1)) - 1) || (s < -(1 << (N-1)));
    uu = u;
    return {of, co, uu[N-1:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] a, b, input logic cin, sub, v);
    A = a; B = b; Cin = cin; Sub = sub; in_valid = v;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) step();
    n_cmp++; if ({ov1, ov2, ov4} !== 3'b000) begin n_err++; $display("FAIL reset_valid: got %b expected 000", {ov1, ov2, ov4}); end
    n_cmp++; if ({s1, s2, s4} !== '0) begin n_err++; $display("FAIL reset_sum: got %h expected 0", {s1, s2, s4}); end
    n_cmp++; if ({co1, co2, co4, of1, of2, of4} !== 6'b0) begin n_err++; $display("FAIL reset_flags: got %b expected 000000", {co1, co2, co4, of1, of2, of4}); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({rdy1, rdy2, rdy4} !== 3'b111) begin n_err++; $display("FAIL reset_ready: got %b expected 111", {rdy1, rdy2, rdy4}); end
  endtask

  typedef struct {
    logic [N-1:0] a, b;
    logic         cin, sub;
    logic [N-1:0] s;
    logic         co, of;
  } vec_t;

  task automatic test_vectors();
    vec_t tv [8];
    tv = '{'{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0},
           '{8'h03, 8'h05, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0},
           '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
           '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0},
           '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1},
           '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1},
           '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0},
           '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1}};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(tv[i].a, tv[i].b, tv[i].cin, tv[i].sub, 1'b1);
      step();
      in_valid = 1'b0;
      n_cmp++; if (ov2 !== 1'b0) begin n_err++; $display("FAIL vec%0d_early_valid: got %b expected 0", i, ov2); end
      step();
      n_cmp++; if (ov2 !== 1'b1) begin n_err++; $display("FAIL vec%0d_valid: got %b expected 1", i, ov2); end
      n_cmp++; if ({of2, co2, s2} !== {tv[i].of, tv[i].co, tv[i].s})
        begin n_err++; $display("FAIL vec%0d_result: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                                i, of2, co2, s2, tv[i].of, tv[i].co, tv[i].s); end
      step();
    end
  endtask

  task automatic test_stream_latency();
    logic         v_obs [3][9];
    logic [N-1:0] s_obs [3][9];
    int           stg [3];
    logic         ev;
    logic [N-1:0] es;
    stg = '{1, 2, 4};
    idle(6);
    for (int e = 0; e < 9; e++) begin
      if (e < 4) drive(N'(8'h10 * (e + 1)), N'(e + 1), 1'b0, 1'b0, 1'b1);
      else in_valid = 1'b0;
      step();
      v_obs[0][e] = ov1; s_obs[0][e] = s1;
      v_obs[1][e] = ov2; s_obs[1][e] = s2;
      v_obs[2][e] = ov4; s_obs[2][e] = s4;
    end
    for (int d = 0; d < 3; d++) begin
      for (int e = 0; e < 9; e++) begin
        ev = (e >= stg[d] - 1) && (e <= stg[d] + 2);
        n_cmp++; if (v_obs[d][e] !== ev) begin n_err++; $display("FAIL stream_s%0d_valid_e%0d: got %b expected %b", stg[d], e, v_obs[d][e], ev); end
        if (ev) begin
          es = N'(8'h11 * (e - stg[d] + 2));
          n_cmp++; if (s_obs[d][e] !== es) begin n_err++; $display("FAIL stream_s%0d_sum_e%0d: got %h expected %h", stg[d], e, s_obs[d][e], es); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] exp_s [4];
    logic [N-1:0] held_s;
    int idx, got, first;
    logic stalled;
    exp_s = '{8'h11, 8'h22, 8'h33, 8'h44};
    idx = 0; got = 0; first = -1; stalled = 1'b0; held_s = '0;
    idle(4);
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (stalled) begin
        n_cmp++; if ({ov2, s2} !== {1'b1, held_s}) begin n_err++; $display("FAIL bp_hold_c%0d: got v=%b sum=%h expected v=1 sum=%h", cyc, ov2, s2, held_s); end
      end
      if (first < 0 && ov2) first = cyc;
      if (idx < 4) drive(N'(8'h10 * (idx + 1)), N'(idx + 1), 1'b0, 1'b0, 1'b1);
      else in_valid = 1'b0;
      out_ready = !(first >= 0 && cyc >= first && cyc < first + 3);
      #1;
      stalled = ov2 && !out_ready;
      held_s = s2;
      if (stalled) begin
        n_cmp++; if (rdy2 !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_c%0d: got %b expected 0", cyc, rdy2); end
      end
      if (ov2 && out_ready) begin
        n_cmp++;
        if (got >= 4) begin n_err++; $display("FAIL bp_extra_result: got sum=%h expected none", s2); end
        else if (s2 !== exp_s[got]) begin n_err++; $display("FAIL bp_result%0d: got %h expected %h", got, s2, exp_s[got]); end
        got++;
      end
      if (idx < 4 && rdy2) idx++;
      step();
    end
    out_ready = 1'b1;
    n_cmp++; if (got !== 4) begin n_err++; $display("FAIL bp_count: got %0d results expected 4", got); end
  endtask

  task automatic test_random_mixed();
    logic [N+1:0] exp_q [$];
    logic [N+1:0] e;
    logic [N+2:0] held;
    logic stalled;
    stalled = 1'b0; held = '0;
    idle(6);
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (stalled) begin
        n_cmp++; if ({ov2, of2, co2, s2} !== held) begin n_err++; $display("FAIL rnd_hold_c%0d: got %h expected %h", cyc, {ov2, of2, co2, s2}, held); end
      end
      drive(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (ov2 && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rnd_unexpected: got %h expected none", {of2, co2, s2}); end
        else begin
          e = exp_q.pop_front();
          if ({of2, co2, s2} !== e) begin n_err++; $display("FAIL rnd_result_c%0d: got %h expected %h", cyc, {of2, co2, s2}, e); end
        end
      end
      if (in_valid && rdy2) exp_q.push_back(model(A, B, Cin, Sub));
      stalled = ov2 && !out_ready;
      held = {ov2, of2, co2, s2};
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (ov2) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rnd_drain_unexpected: got %h expected none", {of2, co2, s2}); end
        else begin
          e = exp_q.pop_front();
          if ({of2, co2, s2} !== e) begin n_err++; $display("FAIL rnd_drain_result: got %h expected %h", {of2, co2, s2}, e); end
        end
      end
      step();
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rnd_leftover: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    idle(6);
    drive(8'h21, 8'h12, 1'b0, 1'b0, 1'b1);
    step();
    drive(8'h40, 8'h05, 1'b1, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if ({ov1, ov2, ov4} !== 3'b000) begin n_err++; $display("FAIL midrst_valid: got %b expected 000", {ov1, ov2, ov4}); end
    n_cmp++; if ({s1, s2, s4} !== '0) begin n_err++; $display("FAIL midrst_sum: got %h expected 0", {s1, s2, s4}); end
    n_cmp++; if ({rdy1, rdy2, rdy4} !== 3'b111) begin n_err++; $display("FAIL midrst_ready: got %b expected 111", {rdy1, rdy2, rdy4}); end
    for (int cyc = 0; cyc < 6; cyc++) begin
      step();
      n_cmp++; if ({ov1, ov2, ov4} !== 3'b000) begin n_err++; $display("FAIL midrst_stale_c%0d: got %b expected 000", cyc, {ov1, ov2, ov4}); end
    end
  endtask

  initial begin
    rst = 1'b1; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    test_reset();
    test_vectors();
    test_stream_latency();
    test_backpressure();
    test_random_mixed();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
